// File: rtl/byte_stage_fifo_pkg.sv
// Shared constants for the byte staging path; BYTE_W is also used by the bus buffer.
package byte_stage_fifo_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned STAGE_DEPTH = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo_ctrl.sv
// Pointer, occupancy and status control for the byte staging FIFO.
module byte_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_wr_valid,
    input  logic          i_rd_ready,
    output logic          o_wr_ready,
    output logic          o_rd_valid,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_ptr,
    output logic [AW:0]   o_count,
    output logic          o_afull,
    output logic          o_ovf
);

    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_wr_fire;
    logic w_rd_fire;

    // Full/empty come only from the registered count, so no RD_READY -> WR_READY path.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_fire = i_wr_valid && !w_full;
    assign w_rd_fire = i_rd_ready && !w_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_fire)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_fire)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_wr_fire && !w_rd_fire)
                r_count <= r_count + CNT_ONE;
            else if (w_rd_fire && !w_wr_fire)
                r_count <= r_count - CNT_ONE;
            if (i_wr_valid && w_full)
                r_ovf <= 1'b1;
        end
    end

    assign o_wr_ready = !w_full;
    assign o_rd_valid = !w_empty;
    assign o_wr_en    = w_wr_fire && !i_reset && !i_flush;
    assign o_wr_ptr   = r_wr_ptr;
    assign o_rd_ptr   = r_rd_ptr;
    assign o_count    = r_count;
    assign o_afull    = (r_count >= AFULL_CNT);
    assign o_ovf      = r_ovf;

endmodule

// File: rtl/byte_stage_fifo.sv
// First-word-fall-through byte FIFO staging operand bytes ahead of the bus buffer.
module byte_stage_fifo
    import byte_stage_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = STAGE_DEPTH,
    parameter int unsigned AW        = 3,
    parameter int unsigned AFULL_LVL = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR_VALID,
    input  logic [BYTE_W-1:0] WR_DATA,
    output logic              WR_READY,
    output logic              RD_VALID,
    output logic [BYTE_W-1:0] RD_DATA,
    input  logic              RD_READY,
    input  logic              FLUSH,
    output logic [AW:0]       COUNT,
    output logic              AFULL,
    output logic              OVF
);

    byte_t         r_mem [DEPTH];
    logic          w_wr_en;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;

    byte_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .AFULL_LVL (AFULL_LVL)
    ) u_ctrl (
        .i_clk      (CLK),
        .i_reset    (RESET),
        .i_flush    (FLUSH),
        .i_wr_valid (WR_VALID),
        .i_rd_ready (RD_READY),
        .o_wr_ready (WR_READY),
        .o_rd_valid (RD_VALID),
        .o_wr_en    (w_wr_en),
        .o_wr_ptr   (w_wr_ptr),
        .o_rd_ptr   (w_rd_ptr),
        .o_count    (COUNT),
        .o_afull    (AFULL),
        .o_ovf      (OVF)
    );

    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[w_wr_ptr] <= WR_DATA;
    end

    // Empty forces zero so a drained FIFO never exposes a stale head byte.
    always_comb begin
        RD_DATA = '0;
        if (RD_VALID)
            RD_DATA = r_mem[w_rd_ptr];
    end

endmodule

// File: tb/tb_byte_stage_fifo.sv
// Directed self-checking bench for byte_stage_fifo (DEPTH=8, AFULL_LVL=6).
module tb_byte_stage_fifo;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WR_VALID;
    logic [7:0] WR_DATA;
    logic       WR_READY;
    logic       RD_VALID;
    logic [7:0] RD_DATA;
    logic       RD_READY;
    logic       FLUSH;
    logic [3:0] COUNT;
    logic       AFULL;
    logic       OVF;

    int unsigned checks = 0;
    int unsigned errors = 0;

    byte_stage_fifo #(
        .DEPTH     (8),
        .AW        (3),
        .AFULL_LVL (6)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .WR_VALID (WR_VALID),
        .WR_DATA  (WR_DATA),
        .WR_READY (WR_READY),
        .RD_VALID (RD_VALID),
        .RD_DATA  (RD_DATA),
        .RD_READY (RD_READY),
        .FLUSH    (FLUSH),
        .COUNT    (COUNT),
        .AFULL    (AFULL),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_valid"}, 32'(RD_VALID), 32'd0);
        check({tag, "_wr_ready"}, 32'(WR_READY), 32'd1);
        check({tag, "_count"},    32'(COUNT),    32'd0);
        check({tag, "_rd_data"},  32'(RD_DATA),  32'h00);
        check({tag, "_ovf"},      32'(OVF),      32'd0);
        check({tag, "_afull"},    32'(AFULL),    32'd0);
    endtask

    initial begin
        RESET = 1'b1; WR_VALID = 1'b0; WR_DATA = 8'h00; RD_READY = 1'b0; FLUSH = 1'b0;

        // 1: reset then idle
        tick(); tick();
        RESET = 1'b0;
        tick();
        check_reset_state("reset");

        // 2: single byte, one-cycle write-to-read
        WR_VALID = 1'b1; WR_DATA = 8'hA5;
        tick();
        WR_VALID = 1'b0;
        check("single_valid", 32'(RD_VALID), 32'd1);
        check("single_data",  32'(RD_DATA),  32'hA5);
        check("single_count", 32'(COUNT),    32'd1);
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        check("single_drain_count", 32'(COUNT),    32'd0);
        check("single_drain_valid", 32'(RD_VALID), 32'd0);
        check("single_drain_data",  32'(RD_DATA),  32'h00);

        // 3: fill, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            WR_VALID = 1'b1; WR_DATA = 8'(i);
            tick();
            check("fill_count",    32'(COUNT),    32'(i));
            check("fill_afull",    32'(AFULL),    (i >= 6) ? 32'd1 : 32'd0);
            check("fill_wr_ready", 32'(WR_READY), (i != 8) ? 32'd1 : 32'd0);
        end
        WR_DATA = 8'hFF;
        tick();
        WR_VALID = 1'b0;
        check("ovf_flag",  32'(OVF),   32'd1);
        check("ovf_count", 32'(COUNT), 32'd8);
        RD_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", 32'(RD_DATA), 32'(i));
            tick();
        end
        RD_READY = 1'b0;
        check("drain_empty_count", 32'(COUNT),    32'd0);
        check("drain_empty_valid", 32'(RD_VALID), 32'd0);
        check("ovf_sticky",        32'(OVF),      32'd1);

        // 4: preload 3, then concurrent read/write across pointer wraps
        for (int i = 0; i < 3; i++) begin
            WR_VALID = 1'b1; WR_DATA = 8'(8'h10 + i);
            tick();
        end
        check("preload_count", 32'(COUNT), 32'd3);
        RD_READY = 1'b1;
        for (int k = 0; k < 20; k++) begin
            WR_DATA = 8'(8'h13 + k);
            check("stream_data", 32'(RD_DATA), 32'(8'h10 + k));
            tick();
            check("stream_count", 32'(COUNT), 32'd3);
        end
        WR_VALID = 1'b0; RD_READY = 1'b0;
        check("stream_head", 32'(RD_DATA), 32'h24);

        // 5: flush at COUNT=4 with OVF set and a concurrent write
        WR_VALID = 1'b1; WR_DATA = 8'h27;
        tick();
        check("preflush_count", 32'(COUNT), 32'd4);
        check("preflush_ovf",   32'(OVF),   32'd1);
        FLUSH = 1'b1; WR_DATA = 8'h77;
        tick();
        FLUSH = 1'b0; WR_VALID = 1'b0;
        check_reset_state("flush");
        RD_READY = 1'b1;
        tick();
        check("empty_read_count", 32'(COUNT), 32'd0);
        check("empty_read_ovf",   32'(OVF),   32'd0);
        RD_READY = 1'b0;
        WR_VALID = 1'b1; WR_DATA = 8'h55;
        tick();
        WR_VALID = 1'b0;
        check("postflush_data",  32'(RD_DATA), 32'h55);
        check("postflush_count", 32'(COUNT),   32'd1);

        // 6: reset mid-burst at COUNT=5
        for (int i = 0; i < 4; i++) begin
            WR_VALID = 1'b1; WR_DATA = 8'(8'h40 + i);
            tick();
        end
        check("preburst_count", 32'(COUNT), 32'd5);
        RESET = 1'b1; WR_DATA = 8'h99;
        tick();
        RESET = 1'b0; WR_VALID = 1'b0;
        check_reset_state("midreset");
        WR_VALID = 1'b1; WR_DATA = 8'h3C;
        tick();
        WR_VALID = 1'b0;
        check("after_reset_data",  32'(RD_DATA),  32'h3C);
        check("after_reset_valid", 32'(RD_VALID), 32'd1);
        check("after_reset_count", 32'(COUNT),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_stage_fifo.md
Name: byte_stage_fifo

Overview:
- Synchronous 8-bit first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the 8-bit bus buffer in the extended DLX datapath.
- Stages TinyML operand bytes from the memory/load path and presents them as a stable 8-bit word to the bus buffer.
- Absorbs back-pressure so the producer is not stalled on every consumer bubble.

Parameters:
- DEPTH, 8, number of byte entries; power of two, 2..64.
- AW, 3, pointer width; must equal log2(DEPTH).
- AFULL_LVL, 6, occupancy at or above which AFULL asserts; range 1..DEPTH.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WR_VALID  in  1  producer has a byte on WR_DATA.
- WR_DATA  in  8  producer byte.
- WR_READY  out  1  FIFO can accept a byte this cycle.
- RD_VALID  out  1  RD_DATA holds a valid head byte.
- RD_DATA  out  8  head byte; feeds the bus buffer input.
- RD_READY  in  1  consumer takes the head byte this cycle.
- FLUSH  in  1  synchronous discard of all contents.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- AFULL  out  1  COUNT >= AFULL_LVL.
- OVF  out  1  sticky error flag: a write was attempted while full.

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-high (RESET). Reset has priority over every other input.
- Reset values: wr_ptr=0, rd_ptr=0, COUNT=0, RD_VALID=0, WR_READY=1, AFULL=0, OVF=0, RD_DATA=8'h00.
- Storage array contents are not reset.
- Write: accepted when WR_VALID && WR_READY. The byte is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Read: occurs when RD_VALID && RD_READY. rd_ptr increments modulo DEPTH.
- WR_READY = (COUNT != DEPTH), registered-equivalent, with no combinational path from RD_READY.
  - When full, a simultaneous read does NOT enable a write in the same cycle.
- RD_VALID = (COUNT != 0).
- RD_DATA = mem[rd_ptr] when RD_VALID; it is 8'h00 when empty. It never shows stale data.
- Latency: a byte written in cycle N is visible on RD_DATA/RD_VALID in cycle N+1 (one-cycle write-to-read). There is no combinational bypass from WR_DATA.
- COUNT update per cycle: +1 on write only; -1 on read only; unchanged on simultaneous write and read, or on neither.
- Pointer wrap: each pointer wraps from DEPTH-1 to 0 with no bubble.
- Full boundary:
  - WR_VALID while full: no store, no pointer change. OVF is set to 1 and stays set until RESET or FLUSH.
  - Contents are unaffected.
- Empty boundary: RD_READY while empty is ignored; no pointer change and no error.
- Simultaneous read/write when COUNT=1: the head is consumed, the new byte is stored, COUNT stays 1, and the new byte appears on RD_DATA the next cycle.
- FLUSH (when RESET=0): pointers go to 0, COUNT to 0, OVF to 0. Any write or read in that cycle is discarded.
  - Next cycle: RD_VALID=0, WR_READY=1.
- RESET mid-operation: all in-flight data is lost. Outputs return to their reset values on the next edge, and the FIFO is usable the following cycle.
- AFULL: combinational from COUNT. It has no hysteresis.
- Widths: COUNT is AW+1 bits so DEPTH is representable. Pointers are AW bits.

Decomposition:
- Shared package/defines file holds the byte width constant BYTE_W=8 and the default depth constant STAGE_DEPTH=8. The bus buffer and this block both reference BYTE_W.
- One natural sub-module: byte_fifo_ctrl, which holds the pointers, COUNT, the full/empty/AFULL/OVF logic and the FLUSH handling.
- The top level holds the storage array and the RD_DATA mux.

Test Plan:
1. Reset then idle: RESET=1 for 2 cycles, then 0 -> RD_VALID=0, WR_READY=1, COUNT=0, RD_DATA=8'h00, OVF=0.
2. Single byte: write 8'hA5 in cycle N with RD_READY=0 -> cycle N+1 RD_VALID=1, RD_DATA=8'hA5, COUNT=1. Assert RD_READY -> next cycle COUNT=0, RD_VALID=0.
3. Fill and overflow, DEPTH=8, AFULL_LVL=6:
   - Write 8'h01..8'h08 -> AFULL asserts when COUNT=6, WR_READY=0 at COUNT=8.
   - Extra write of 8'hFF -> OVF=1, COUNT stays 8.
   - Drain -> order is 01..08, and 8'hFF never appears.
4. Wrap-around with concurrent traffic: preload 3 bytes, then write and read every cycle for 20 cycles with incrementing data -> COUNT stays 3 and the output sequence is exact, with no gaps across the pointer wrap.
5. FLUSH while half full (COUNT=4, OVF=1) with a concurrent write of 8'h77 -> next cycle COUNT=0, RD_VALID=0, OVF=0. 8'h77 is never read out.
6. RESET mid-burst at COUNT=5 with WR_VALID=1 -> next cycle all outputs are at their reset values. Write 8'h3C -> read back 8'h3C after one cycle.
